mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-access stage of the pipelined RISC-V core. It sits directly after the Execute/Memory pipeline register and consumes its outputs. It issues loads and stores to data memory over a valid/ready request and valid response handshake, and stalls the front of the pipeline while an access is outstanding. It formats load and store data for byte, half and word accesses, selects the writeback result, and registers the Memory/Writeback stage state.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-low reset.
- ALUResultM  in  32  ALU result; byte address for memory ops.
- WriteDataM  in  32  store data, unaligned in the low bits.
- RdM  in  5  destination register.
- PCPlus4M  in  32  link value.
- RegWriteM  in  1  instruction writes the register file.
- MemReadM  in  1  load.
- MemWriteM  in  1  store; never asserted together with MemReadM.
- Funct3M  in  3  access size and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- ResultSrcM  in  2  writeback select: 00 ALU, 01 load data, 10 PC+4.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  32  word address, {ALUResultM[31:2],2'b00}.
- dmem_we  out  1  request is a store.
- dmem_wstrb  out  4  byte-lane enables; 0 for loads.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rdata  in  32  load word.
- StallM  out  1  holds PC, F/D, D/E and E/M registers.
- MisalignM  out  1  misaligned access flag; tied 0 unless the macro is defined.
- ResultW  out  32  registered writeback data.
- RdW  out  5  registered destination register.
- RegWriteW  out  1  registered write enable.

## Operation
- FSM states:
  - IDLE: a request may be issued.
  - WAIT: a load has been accepted and its response is pending.
- IDLE with MemReadM or MemWriteM:
  - dmem_req_valid=1, driven combinationally from the M-stage inputs.
  - The inputs stay stable while StallM=1, so the request holds until accepted.
- Request acceptance (valid and ready in the same cycle):
  - Store: completes that cycle; state stays IDLE.
  - Load: moves to WAIT.
- WAIT:
  - dmem_req_valid=0.
  - On dmem_rsp_valid the load completes and the state returns to IDLE.
- Complete means a non-memory instruction, an accepted store, or a load response.
- StallM = (MemReadM|MemWriteM) & !complete.
- Store formatting:
  - sb: wdata={4{WriteDataM[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{WriteDataM[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - sw: wdata=WriteDataM, wstrb=4'b1111.
- Load formatting: select the lane by addr[1:0] (half by addr[1]), then sign-extend (lb/lh) or zero-extend (lbu/lhu). lw passes through.
- Writeback register, updated every clk edge:
  - Complete cycle: load RdM and RegWriteM, plus ResultW chosen by ResultSrcM (ResultSrcM=11 gives 0).
  - Stall cycle: load a bubble, RegWriteW=0, RdW=0, ResultW=0.
- dmem_rsp_valid in IDLE is ignored, which covers a stale response after reset.

## Timing
- Reset values:
  - state IDLE, ResultW=0, RdW=0, RegWriteW=0.
  - The combinational outputs follow from the inputs in IDLE; with no memory op, dmem_req_valid=0.
- Reset mid-access abandons the outstanding load; the pipeline upstream is reset as well.
- Non-memory op: latency 1; ResultW is valid after the next edge and StallM=0.
- Store with ready high on the first cycle: no stall.
- Each cycle ready stays low adds one stall cycle.
- Load:
  - The response may arrive no earlier than the cycle after acceptance.
  - With ready=1 and a one-cycle response: StallM=1 for exactly one cycle.
  - ResultW is valid after the edge that ends the response cycle.
- WAIT with no response: StallM stays 1 indefinitely; no timeout.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned cases are a half access with addr[0]=1, or a word access with addr[1:0]≠0.
  - For a misaligned access: no request, MisalignM=1 for that cycle, StallM=0, and the W register captures a bubble.
- Undefined:
  - MisalignM=0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].

## Test plan
- ALU op, ALUResultM=0x1234, ResultSrcM=00, RdM=5 -> next edge ResultW=0x1234, RdW=5, RegWriteW=1; StallM never asserted.
- sb with addr=0x103, data=0xAB, ready=1 -> dmem_addr=0x100, wstrb=4'b1000, wdata=0xABABABAB, StallM=0.
- lb with addr=0x102, ready=1, rsp next cycle with rdata=0x00F00000 -> one stall cycle; ResultW=0xFFFFFFF0.
  - lbu on the same stimulus -> ResultW=0x000000F0.
- lhu with ready low for 3 cycles, then response after 2 cycles -> StallM high 5 cycles, RegWriteW=0 during the stall, exactly one writeback.
- reset low in WAIT, then rsp_valid pulses after reset releases -> outputs at reset values; the response is ignored.
- With LSU_MISALIGN_TRAP_EN, lw at addr 0x102 -> dmem_req_valid=0, MisalignM=1, RegWriteW=0 next edge.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-access stage of the pipelined RISC-V core. It consumes the
// Execute/Memory pipeline register outputs. It issues loads and stores over a
// valid/ready request channel with a separate valid-only response channel. It
// stalls the front of the pipeline while an access is outstanding. It formats
// byte/half/word store and load data, selects the writeback value, and
// registers the Memory/Writeback stage state.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word accesses are
//                          flagged on MisalignM, issue no request and retire
//                          as a bubble. When undefined, MisalignM is tied to 0
//                          and the low address bits a size does not use are
//                          ignored.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   ALUResultM            byte address for memory ops / ALU result
//   WriteDataM            store data, right-aligned
//   RdM, RegWriteM        destination register and its write enable
//   PCPlus4M              link value for writeback
//   MemReadM, MemWriteM   load / store (mutually exclusive)
//   Funct3M               access size and signedness
//   ResultSrcM            writeback select: 00 ALU, 01 load, 10 PC+4, 11 zero
//   dmem_req_*            request channel (valid/ready, addr, we, wstrb, wdata)
//   dmem_rsp_*            load response channel (valid, rdata)
//   StallM                holds PC, F/D, D/E and E/M while an access is pending
//   MisalignM             misaligned-access flag
//   ResultW, RdW,
//   RegWriteW             registered Memory/Writeback stage state
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  RegWriteM,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [1:0]            ResultSrcM,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic                  dmem_we,
    output logic [3:0]            dmem_wstrb,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  StallM,
    output logic                  MisalignM,
    output logic [DATA_WIDTH-1:0] ResultW,
    output logic [4:0]            RdW,
    output logic                  RegWriteW
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic                  mem_op;
    logic                  misalign;
    logic                  complete;
    logic                  trap;
    logic                  req_valid;
    logic [1:0]            byte_off;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] wb_sel;

    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            rd_q, rd_d;
    logic                  regwrite_q, regwrite_d;

    assign mem_op   = MemReadM | MemWriteM;
    assign byte_off = ALUResultM[1:0];

    // -----------------------------------------------------------------------
    // Misaligned-access detection (optional)
    // -----------------------------------------------------------------------
`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_op && (state_q == S_IDLE)) begin
            case (Funct3M[1:0])
                2'b01:   misalign = byte_off[0];
                2'b10:   misalign = (byte_off != 2'b00);
                default: misalign = 1'b0;
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign MisalignM = misalign;

    // -----------------------------------------------------------------------
    // Store formatting: replicate data across lanes, enable the target lanes
    // -----------------------------------------------------------------------
    always_comb begin
        strb  = 4'b1111;
        wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                wdata = {4{WriteDataM[7:0]}};
                strb  = 4'b0001 << byte_off;
            end
            2'b01: begin
                wdata = {2{WriteDataM[15:0]}};
                strb  = 4'b0011 << {byte_off[1], 1'b0};
            end
            default: begin
                wdata = WriteDataM;
                strb  = 4'b1111;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load formatting: lane select then sign/zero extension
    // -----------------------------------------------------------------------
    always_comb begin
        ld_byte = '0;
        case (byte_off)
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        ld_data = dmem_rdata;
        case (Funct3M)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // -----------------------------------------------------------------------
    // Access FSM: next state, request, completion
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        complete  = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A response arriving here belongs to no outstanding load
                // (e.g. issued before a reset) and is dropped.
                if (!mem_op) begin
                    complete = 1'b1;
                end else if (misalign) begin
                    trap = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        if (MemWriteM) begin
                            complete = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rsp_valid) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign StallM         = mem_op & ~complete & ~trap;
    assign dmem_req_valid = req_valid;
    assign dmem_addr      = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign dmem_we        = req_valid & MemWriteM;
    assign dmem_wstrb     = (req_valid & MemWriteM) ? strb : 4'b0000;
    assign dmem_wdata     = wdata;

    // -----------------------------------------------------------------------
    // Writeback select and M/W register next state
    // -----------------------------------------------------------------------
    always_comb begin
        case (ResultSrcM)
            2'b00:   wb_sel = ALUResultM;
            2'b01:   wb_sel = ld_data;
            2'b10:   wb_sel = PCPlus4M;
            default: wb_sel = '0;
        endcase
    end

    always_comb begin
        result_d   = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        // Stalled and trapped cycles retire a bubble.
        if (complete) begin
            result_d   = wb_sel;
            rd_d       = RdM;
            regwrite_d = RegWriteM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign ResultW   = result_q;
    assign RdW       = rd_q;
    assign RegWriteW = regwrite_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        RegWriteM;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [1:0]  ResultSrcM;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        MisalignM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .RdM            (RdM),
        .PCPlus4M       (PCPlus4M),
        .RegWriteM      (RegWriteM),
        .MemReadM       (MemReadM),
        .MemWriteM      (MemWriteM),
        .Funct3M        (Funct3M),
        .ResultSrcM     (ResultSrcM),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .StallM         (StallM),
        .MisalignM      (MisalignM),
        .ResultW        (ResultW),
        .RdW            (RdW),
        .RegWriteW      (RegWriteW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        ALUResultM     = '0;
        WriteDataM     = '0;
        RdM            = '0;
        PCPlus4M       = '0;
        RegWriteM      = 1'b0;
        MemReadM       = 1'b0;
        MemWriteM      = 1'b0;
        Funct3M        = 3'b000;
        ResultSrcM     = 2'b00;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        total++; if (ResultW !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=00000000", ResultW); end
        total++; if (RdW !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d exp=0", RdW); end
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL rst_regwrite got=%b exp=0", RegWriteW); end
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", dmem_req_valid); end
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL rst_hold_regwrite got=%b exp=0", RegWriteW); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu();
        // back-to-back non-memory ops, one per cycle, each with latency 1
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_1234; RdM = 5'd5; RegWriteM = 1'b1; ResultSrcM = 2'b00;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", StallM); end
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL alu_valid got=%b exp=0", dmem_req_valid); end
        @(posedge clk); #1;
        total++; if (ResultW !== 32'h0000_1234) begin bad++; $display("FAIL alu_result got=%h exp=00001234", ResultW); end
        total++; if (RdW !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", RdW); end
        total++; if (RegWriteW !== 1'b1) begin bad++; $display("FAIL alu_regwrite got=%b exp=1", RegWriteW); end
        @(negedge clk);
        PCPlus4M = 32'h0000_0404; RdM = 5'd1; ResultSrcM = 2'b10;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL jal_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (ResultW !== 32'h0000_0404) begin bad++; $display("FAIL jal_result got=%h exp=00000404", ResultW); end
        total++; if (RdW !== 5'd1) begin bad++; $display("FAIL jal_rd got=%0d exp=1", RdW); end
        @(negedge clk);
        ResultSrcM = 2'b11; RdM = 5'd3; RegWriteM = 1'b0;
        @(posedge clk); #1;
        total++; if (ResultW !== 32'h0) begin bad++; $display("FAIL sel11_result got=%h exp=00000000", ResultW); end
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL sel11_regwrite got=%b exp=0", RegWriteW); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_store();
        // sb, ready high immediately
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_0103; WriteDataM = 32'h0000_00AB; MemWriteM = 1'b1;
        Funct3M = 3'b000; RdM = 5'd4; dmem_req_ready = 1'b1;
        #1;
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL sb_valid got=%b exp=1", dmem_req_valid); end
        total++; if (dmem_addr !== 32'h0000_0100) begin bad++; $display("FAIL sb_addr got=%h exp=00000100", dmem_addr); end
        total++; if (dmem_wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b exp=1000", dmem_wstrb); end
        total++; if (dmem_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_wdata); end
        total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL sb_we got=%b exp=1", dmem_we); end
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL sb_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (RdW !== 5'd4) begin bad++; $display("FAIL sb_rdw got=%0d exp=4", RdW); end
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL sb_regwrite got=%b exp=0", RegWriteW); end

        // sh with ready low for one cycle: one stall then completion
        @(negedge clk);
        ALUResultM = 32'h0000_0102; WriteDataM = 32'h1234_CDEF; Funct3M = 3'b001;
        dmem_req_ready = 1'b0;
        #1;
        total++; if (StallM !== 1'b1) begin bad++; $display("FAIL sh_wait_stall got=%b exp=1", StallM); end
        total++; if (dmem_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb got=%b exp=1100", dmem_wstrb); end
        total++; if (dmem_wdata !== 32'hCDEF_CDEF) begin bad++; $display("FAIL sh_wdata got=%h exp=cdefcdef", dmem_wdata); end
        @(posedge clk); #1;
        total++; if (RegWriteW !== 1'b0 || RdW !== 5'd0) begin bad++; $display("FAIL sh_bubble got=%b/%0d exp=0/0", RegWriteW, RdW); end
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL sh_accept_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (RdW !== 5'd4) begin bad++; $display("FAIL sh_rdw got=%0d exp=4", RdW); end

        // sw
        @(negedge clk);
        ALUResultM = 32'h0000_0200; WriteDataM = 32'h89AB_CDEF; Funct3M = 3'b010;
        #1;
        total++; if (dmem_wstrb !== 4'b1111) begin bad++; $display("FAIL sw_wstrb got=%b exp=1111", dmem_wstrb); end
        total++; if (dmem_wdata !== 32'h89AB_CDEF) begin bad++; $display("FAIL sw_wdata got=%h exp=89abcdef", dmem_wdata); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_0102; MemReadM = 1'b1; Funct3M = f3; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd7; dmem_req_ready = 1'b1;
        #1;
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL ld_valid got=%b exp=1", dmem_req_valid); end
        total++; if (StallM !== 1'b1) begin bad++; $display("FAIL ld_stall got=%b exp=1", StallM); end
        total++; if (dmem_wstrb !== 4'b0000 || dmem_we !== 1'b0) begin bad++; $display("FAIL ld_wstrb got=%b/%b exp=0000/0", dmem_wstrb, dmem_we); end
        @(posedge clk); #1;
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL ld_bubble got=%b exp=0", RegWriteW); end
        @(negedge clk);
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h00F0_0000;
        #1;
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL ld_wait_valid got=%b exp=0", dmem_req_valid); end
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL ld_rsp_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (ResultW !== exp) begin bad++; $display("FAIL ld_f3_%b_result got=%h exp=%h", f3, ResultW, exp); end
        total++; if (RdW !== 5'd7 || RegWriteW !== 1'b1) begin bad++; $display("FAIL ld_wb got=%0d/%b exp=7/1", RdW, RegWriteW); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_lhu_slow();
        int stalls = 0;
        int wbs    = 0;
        int bubble_bad = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_0202; MemReadM = 1'b1; Funct3M = 3'b101; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd9;
        for (int c = 0; c < 20 && wbs == 0; c++) begin
            if (c != 0) @(negedge clk);
            dmem_req_ready = (c >= 3);
            dmem_rsp_valid = (c == 5);
            dmem_rdata     = (c == 5) ? 32'h8765_4321 : 32'h0;
            #1;
            if (StallM === 1'b1) stalls++;
            @(posedge clk); #1;
            if (RegWriteW === 1'b1) begin
                wbs++;
                res = ResultW;
            end else if (StallM !== 1'b1 && c < 5) begin
                bubble_bad++;
            end
        end
        total++; if (stalls != 5) begin bad++; $display("FAIL lhu_stall_cycles got=%0d exp=5", stalls); end
        total++; if (wbs != 1) begin bad++; $display("FAIL lhu_writebacks got=%0d exp=1", wbs); end
        total++; if (res !== 32'h0000_8765) begin bad++; $display("FAIL lhu_result got=%h exp=00008765", res); end
        total++; if (bubble_bad != 0) begin bad++; $display("FAIL lhu_bubble got=%0d exp=0", bubble_bad); end
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL lhu_after_stall got=%b exp=0", StallM); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_0300; MemReadM = 1'b1; Funct3M = 3'b010; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd11; dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        total++; if (StallM !== 1'b1 || dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rm_wait got=%b/%b exp=1/0", StallM, dmem_req_valid); end
        reset = 1'b0;
        idle_inputs();
        #1;
        total++; if (ResultW !== 32'h0 || RdW !== 5'd0 || RegWriteW !== 1'b0) begin bad++; $display("FAIL rm_wreg got=%h/%0d/%b exp=0/0/0", ResultW, RdW, RegWriteW); end
        total++; if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rm_comb got=%b/%b exp=0/0", StallM, dmem_req_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        // stale response while a fresh load is still waiting for acceptance
        ALUResultM = 32'h0000_0300; MemReadM = 1'b1; Funct3M = 3'b010; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd11; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL rm_idle_valid got=%b exp=1", dmem_req_valid); end
        total++; if (StallM !== 1'b1) begin bad++; $display("FAIL rm_stale_stall got=%b exp=1", StallM); end
        @(posedge clk); #1;
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL rm_stale_wb got=%b exp=0", RegWriteW); end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        idle_inputs();
        ALUResultM = 32'h0000_0102; MemReadM = 1'b1; Funct3M = 3'b010; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd12; dmem_req_ready = 1'b1;
        #1;
`ifdef LSU_MISALIGN_TRAP_EN
        total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", dmem_req_valid); end
        total++; if (MisalignM !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", MisalignM); end
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b exp=0", StallM); end
        @(posedge clk); #1;
        total++; if (RegWriteW !== 1'b0) begin bad++; $display("FAIL mis_wb got=%b exp=0", RegWriteW); end
`else
        total++; if (MisalignM !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b exp=0", MisalignM); end
        total++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h0000_0100) begin bad++; $display("FAIL mis_req got=%b/%h exp=1/00000100", dmem_req_valid, dmem_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        total++; if (ResultW !== 32'hCAFE_F00D || RegWriteW !== 1'b1) begin bad++; $display("FAIL mis_lw got=%h/%b exp=cafef00d/1", ResultW, RegWriteW); end
`endif
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load_byte(3'b000, 32'hFFFF_FFF0);
        test_load_byte(3'b100, 32'h0000_00F0);
        test_lhu_slow();
        test_reset_mid_access();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
